// File: rtl/card_pkg.sv
// Shared types and lookup functions for the baccarat hand display: rank encoding,
// seven-segment patterns (active-low, bit order g..a) and card point values.
package card_pkg;

    typedef logic [3:0] rank_t;

    localparam rank_t RANK_EMPTY = 4'd0;
    localparam rank_t RANK_A     = 4'd1;
    localparam rank_t RANK_9     = 4'd9;
    localparam rank_t RANK_10    = 4'd10;
    localparam rank_t RANK_J     = 4'd11;
    localparam rank_t RANK_Q     = 4'd12;
    localparam rank_t RANK_K     = 4'd13;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } phase_e;

    function automatic logic [6:0] card_seg(input rank_t rank);
        logic [6:0] seg;
        case (rank)
            RANK_A:  seg = 7'b0001000;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            RANK_9:  seg = 7'b0010000;
            RANK_10: seg = 7'b1000000;
            RANK_J:  seg = 7'b1100001;
            RANK_Q:  seg = 7'b0011000;
            RANK_K:  seg = 7'b0001001;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] score_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Tens and court cards score zero in baccarat, as do empty slots.
    function automatic logic [3:0] card_value(input rank_t rank);
        return (rank >= RANK_A && rank <= RANK_9) ? rank : 4'd0;
    endfunction

endpackage

// File: rtl/card_seg_decode.sv
// Combinational rank-to-segment decoder for a single card digit.
module card_seg_decode
    import card_pkg::*;
(
    input  logic [3:0] rank_i,
    output logic [6:0] seg_o
);

    assign seg_o = card_seg(rank_i);

endmodule

// File: rtl/card_hand_display.sv
// Display bank for one baccarat hand: slot registers, per-slot card digits with
// blinking of the last dealt card, and a registered score digit.
module card_hand_display
    import card_pkg::*;
#(
    parameter  int NUM_SLOTS    = 3,
    parameter  int BLINK_PERIOD = 25_000_000,
    localparam int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   clear,
    input  logic                   load_valid,
    input  logic [SLOT_W-1:0]      load_slot,
    input  logic [3:0]             load_card,
    input  logic                   blink_en,
    output logic [NUM_SLOTS*7-1:0] hex_out,
    output logic [3:0]             score,
    output logic [6:0]             score_hex,
    output logic                   full
);

    localparam int CNT_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

    rank_t                  slot_q [NUM_SLOTS];
    rank_t                  slot_d [NUM_SLOTS];
    logic [SLOT_W-1:0]      last_slot_q, last_slot_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    phase_e                 phase_q, phase_d;
    logic [NUM_SLOTS*7-1:0] hex_q, hex_d;
    logic [3:0]             score_q, score_d;
    logic [6:0]             score_hex_q, score_hex_d;
    logic                   full_q, full_d;

    logic [6:0]             seg [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   slot_full;
    logic [6:0]             value_sum;
    logic                   in_range;
    logic                   accept;

    // Widened by one bit so NUM_SLOTS itself is representable in the compare.
    assign in_range = {1'b0, load_slot} < (SLOT_W + 1)'(NUM_SLOTS);
    assign accept   = load_valid && !clear && in_range;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign slot_d[gi] = clear ? RANK_EMPTY :
                            (accept && load_slot == SLOT_W'(gi)) ? load_card :
                            slot_q[gi];

        card_seg_decode u_decode (
            .rank_i (slot_q[gi]),
            .seg_o  (seg[gi])
        );

        assign slot_full[gi] = (slot_q[gi] >= RANK_A) && (slot_q[gi] <= RANK_K);

        assign hex_d[gi*7 +: 7] =
            (blink_en && phase_q == PHASE_OFF && last_slot_q == SLOT_W'(gi)) ?
            SEG_BLANK : seg[gi];
    end

    always_comb begin
        value_sum = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            value_sum = value_sum + {3'b000, card_value(slot_q[i])};
        end
    end

    assign score_d     = 4'(value_sum % 7'd10);
    assign score_hex_d = score_seg(score_d);
    assign full_d      = &slot_full;

    // Any accepted load restarts the ON half-period so the new card shows at once.
    always_comb begin
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        last_slot_d = last_slot_q;
        if (clear) begin
            cnt_d       = '0;
            phase_d     = PHASE_ON;
            last_slot_d = '0;
        end else if (accept) begin
            cnt_d       = '0;
            phase_d     = PHASE_ON;
            last_slot_d = load_slot;
        end else if (cnt_q == CNT_W'(BLINK_PERIOD - 1)) begin
            cnt_d   = '0;
            phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= RANK_EMPTY;
            end
            last_slot_q <= '0;
            cnt_q       <= '0;
            phase_q     <= PHASE_ON;
            hex_q       <= '1;
            score_q     <= '0;
            score_hex_q <= SEG_ZERO;
            full_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            last_slot_q <= last_slot_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            hex_q       <= hex_d;
            score_q     <= score_d;
            score_hex_q <= score_hex_d;
            full_q      <= full_d;
        end
    end

    assign hex_out   = hex_q;
    assign score     = score_q;
    assign score_hex = score_hex_q;
    assign full      = full_q;

endmodule
